// File: rtl/bus_arbiter_if.sv
// Bundle of requester-side and downstream-side signals for bus_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface bus_arbiter_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned ACC_W     = 2
);
    logic [XLEN-1:0]      m0_addr,  m1_addr;
    logic                 m0_w_rb,  m1_w_rb;
    logic [ACC_W-1:0]     m0_acc,   m1_acc;
    logic [BUS_WIDTH-1:0] m0_wdata, m1_wdata;
    logic                 m0_req,   m1_req;
    logic                 m0_resp,  m1_resp;
    logic [BUS_WIDTH-1:0] m0_rdata, m1_rdata;
    logic                 m0_fault, m1_fault;

    logic [XLEN-1:0]      s_addr;
    logic                 s_w_rb;
    logic [ACC_W-1:0]     s_acc;
    logic [BUS_WIDTH-1:0] s_wdata;
    logic                 s_req;
    logic                 s_resp;
    logic [BUS_WIDTH-1:0] s_rdata;
    logic                 s_fault;

    modport slave (
        input  m0_addr, m1_addr, m0_w_rb, m1_w_rb, m0_acc, m1_acc,
        input  m0_wdata, m1_wdata, m0_req, m1_req,
        output m0_resp, m1_resp, m0_rdata, m1_rdata, m0_fault, m1_fault,
        output s_addr, s_w_rb, s_acc, s_wdata, s_req,
        input  s_resp, s_rdata, s_fault
    );

    modport master (
        output m0_addr, m1_addr, m0_w_rb, m1_w_rb, m0_acc, m1_acc,
        output m0_wdata, m1_wdata, m0_req, m1_req,
        input  m0_resp, m1_resp, m0_rdata, m1_rdata, m0_fault, m1_fault,
        input  s_addr, s_w_rb, s_acc, s_wdata, s_req,
        output s_resp, s_rdata, s_fault
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto one downstream port, one transaction in flight.
// Optional WAIT watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned ACC_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_grant;
    logic                 r_s_req;
    logic [XLEN-1:0]      r_s_addr;
    logic                 r_s_w_rb;
    logic [ACC_W-1:0]     r_s_acc;
    logic [BUS_WIDTH-1:0] r_s_wdata;
    logic                 r_m0_resp, r_m1_resp;
    logic                 r_m0_fault, r_m1_fault;
    logic [BUS_WIDTH-1:0] r_m0_rdata, r_m1_rdata;

    logic w_req0, w_req1, w_pick, w_issue, w_done, w_timeout_hit, w_tout;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be nonzero");
    end

    // A master pulsing resp this cycle is masked so its held req is not reissued.
    assign w_req0 = bus.m0_req & ~r_m0_resp;
    assign w_req1 = bus.m1_req & ~r_m1_resp;
    assign w_pick = (w_req0 & w_req1) ? ~r_grant : w_req1;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_wait_cnt <= '0;
        else if (r_state != ST_WAIT) r_wait_cnt <= '0;
        else                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end

    assign w_timeout_hit = (r_state == ST_WAIT) &&
                           (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout_hit = 1'b0;
`endif

    assign w_tout = w_timeout_hit & ~bus.s_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req0 | w_req1) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.s_resp | w_timeout_hit) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant pointer doubles as the last-grant record; reset favours m0 on the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= 1'b1;
            r_s_req    <= 1'b0;
            r_s_addr   <= '0;
            r_s_w_rb   <= 1'b0;
            r_s_acc    <= '0;
            r_s_wdata  <= '0;
            r_m0_resp  <= 1'b0;
            r_m1_resp  <= 1'b0;
            r_m0_fault <= 1'b0;
            r_m1_fault <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            r_s_req    <= w_issue;
            r_m0_resp  <= w_done & ~r_grant;
            r_m1_resp  <= w_done &  r_grant;
            r_m0_fault <= w_done & ~r_grant & (w_tout | bus.s_fault);
            r_m1_fault <= w_done &  r_grant & (w_tout | bus.s_fault);
            r_m0_rdata <= (w_done && !r_grant && !w_tout) ? bus.s_rdata : '0;
            r_m1_rdata <= (w_done &&  r_grant && !w_tout) ? bus.s_rdata : '0;
            if (w_issue) begin
                r_grant <= w_pick;
                if (w_pick) begin
                    r_s_addr  <= bus.m1_addr;
                    r_s_w_rb  <= bus.m1_w_rb;
                    r_s_acc   <= bus.m1_acc;
                    r_s_wdata <= bus.m1_wdata;
                end else begin
                    r_s_addr  <= bus.m0_addr;
                    r_s_w_rb  <= bus.m0_w_rb;
                    r_s_acc   <= bus.m0_acc;
                    r_s_wdata <= bus.m0_wdata;
                end
            end
        end
    end

    assign bus.s_req    = r_s_req;
    assign bus.s_addr   = r_s_addr;
    assign bus.s_w_rb   = r_s_w_rb;
    assign bus.s_acc    = r_s_acc;
    assign bus.s_wdata  = r_s_wdata;
    assign bus.m0_resp  = r_m0_resp;
    assign bus.m1_resp  = r_m1_resp;
    assign bus.m0_fault = r_m0_fault;
    assign bus.m1_fault = r_m1_fault;
    assign bus.m0_rdata = r_m0_rdata;
    assign bus.m1_rdata = r_m1_rdata;
endmodule
